// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pipeline_ctrl_if : ID control bundle, dmem handshake and pipeline controls (rev 1.0)
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;
  logic       id_valid_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic [4:0] id_rd_i;
  logic       id_uses_rs1_i;
  logic       id_uses_rs2_i;
  logic       id_reg_write_i;
  logic       id_alu_src_i;
  logic       id_mem_read_i;
  logic       id_mem_write_i;
  logic       id_mem_to_reg_i;
  logic       id_branch_i;
  logic [1:0] id_alu_op_i;
  logic       ex_branch_taken_i;
  logic       dmem_ack_i;

  logic       pc_stall_o;
  logic       if_id_stall_o;
  logic       if_id_flush_o;
  logic       ex_valid_o;
  logic       ex_reg_write_o;
  logic       ex_alu_src_o;
  logic       ex_mem_read_o;
  logic       ex_mem_write_o;
  logic       ex_mem_to_reg_o;
  logic       ex_branch_o;
  logic [1:0] ex_alu_op_o;
  logic [4:0] ex_rd_o;
  logic [1:0] fwd_a_o;
  logic [1:0] fwd_b_o;
  logic       mem_valid_o;
  logic       mem_reg_write_o;
  logic       mem_mem_to_reg_o;
  logic [4:0] mem_rd_o;
  logic       dmem_req_o;
  logic       dmem_we_o;
  logic       wb_reg_write_o;
  logic       wb_mem_to_reg_o;
  logic [4:0] wb_rd_o;
  logic       mem_timeout_o;

  // Datapath / memory side drives ID controls and the memory acknowledge.
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i,
           id_reg_write_i, id_alu_src_i, id_mem_read_i, id_mem_write_i,
           id_mem_to_reg_i, id_branch_i, id_alu_op_i, ex_branch_taken_i, dmem_ack_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, ex_valid_o, ex_reg_write_o,
           ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_branch_o,
           ex_alu_op_o, ex_rd_o, fwd_a_o, fwd_b_o, mem_valid_o, mem_reg_write_o,
           mem_mem_to_reg_o, mem_rd_o, dmem_req_o, dmem_we_o, wb_reg_write_o,
           wb_mem_to_reg_o, wb_rd_o, mem_timeout_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i,
           id_reg_write_i, id_alu_src_i, id_mem_read_i, id_mem_write_i,
           id_mem_to_reg_i, id_branch_i, id_alu_op_i, ex_branch_taken_i, dmem_ack_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, ex_valid_o, ex_reg_write_o,
           ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_branch_o,
           ex_alu_op_o, ex_rd_o, fwd_a_o, fwd_b_o, mem_valid_o, mem_reg_write_o,
           mem_mem_to_reg_o, mem_rd_o, dmem_req_o, dmem_we_o, wb_reg_write_o,
           wb_mem_to_reg_o, wb_rd_o, mem_timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pipeline_ctrl : 5-stage RISC-V stall/flush/forwarding/dmem-wait sequencer (rev 1.0)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] alu_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_stage_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } wb_stage_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  ex_stage_t  ex_q, ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q, wb_d;

  logic w_memop;
  logic w_freeze;
  logic w_flush;
  logic w_loaduse;
  logic w_stall;
  logic w_mem_fwd_ok;
  logic w_wb_fwd_ok;

  assign w_memop  = mem_q.valid & (mem_q.mem_read | mem_q.mem_write);
  assign w_freeze = w_memop & ~bus.dmem_ack_i;
  assign w_flush  = ex_q.valid & ex_q.branch & bus.ex_branch_taken_i & ~w_freeze;
  assign w_loaduse = bus.id_valid_i & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                     ((bus.id_uses_rs1_i & (bus.id_rs1_i == ex_q.rd)) |
                      (bus.id_uses_rs2_i & (bus.id_rs2_i == ex_q.rd)));
  // A load-use stall is moot when the younger instruction is being flushed anyway.
  assign w_stall  = w_freeze | (w_loaduse & ~w_flush);

  assign w_mem_fwd_ok = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0);
  assign w_wb_fwd_ok  = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;

    case (state_q)
      ST_RUN: begin
        if (w_freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (wait_cnt_q != C_MAX_WAIT) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (wait_cnt_d == C_MAX_WAIT) begin
          timeout_d = 1'b1;
        end
        if (bus.dmem_ack_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (!w_freeze) begin
      wb_d.valid      = mem_q.valid;
      wb_d.reg_write  = mem_q.reg_write;
      wb_d.mem_to_reg = mem_q.mem_to_reg;
      wb_d.rd         = mem_q.rd;

      mem_d.valid      = ex_q.valid;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.rd         = ex_q.rd;

      // Bubbles carry all-zero controls so downstream gating never sees stale fields.
      if (w_flush || w_loaduse || !bus.id_valid_i) begin
        ex_d = '0;
      end else begin
        ex_d.valid      = 1'b1;
        ex_d.reg_write  = bus.id_reg_write_i;
        ex_d.alu_src    = bus.id_alu_src_i;
        ex_d.mem_read   = bus.id_mem_read_i;
        ex_d.mem_write  = bus.id_mem_write_i;
        ex_d.mem_to_reg = bus.id_mem_to_reg_i;
        ex_d.branch     = bus.id_branch_i;
        ex_d.alu_op     = bus.id_alu_op_i;
        ex_d.rd         = bus.id_rd_i;
        ex_d.rs1        = bus.id_rs1_i;
        ex_d.rs2        = bus.id_rs2_i;
      end
    end
  end

  assign bus.pc_stall_o    = w_stall;
  assign bus.if_id_stall_o = w_stall;
  assign bus.if_id_flush_o = w_flush;

  assign bus.ex_valid_o      = ex_q.valid;
  assign bus.ex_reg_write_o  = ex_q.valid & ex_q.reg_write;
  assign bus.ex_alu_src_o    = ex_q.valid & ex_q.alu_src;
  assign bus.ex_mem_read_o   = ex_q.valid & ex_q.mem_read;
  assign bus.ex_mem_write_o  = ex_q.valid & ex_q.mem_write;
  assign bus.ex_mem_to_reg_o = ex_q.valid & ex_q.mem_to_reg;
  assign bus.ex_branch_o     = ex_q.valid & ex_q.branch;
  assign bus.ex_alu_op_o     = ex_q.alu_op;
  assign bus.ex_rd_o         = ex_q.rd;

  assign bus.fwd_a_o = !ex_q.valid                              ? 2'b00 :
                       (w_mem_fwd_ok && mem_q.rd == ex_q.rs1)   ? 2'b10 :
                       (w_wb_fwd_ok  && wb_q.rd  == ex_q.rs1)   ? 2'b01 : 2'b00;
  assign bus.fwd_b_o = !ex_q.valid                              ? 2'b00 :
                       (w_mem_fwd_ok && mem_q.rd == ex_q.rs2)   ? 2'b10 :
                       (w_wb_fwd_ok  && wb_q.rd  == ex_q.rs2)   ? 2'b01 : 2'b00;

  assign bus.mem_valid_o      = mem_q.valid;
  assign bus.mem_reg_write_o  = mem_q.valid & mem_q.reg_write;
  assign bus.mem_mem_to_reg_o = mem_q.valid & mem_q.mem_to_reg;
  assign bus.mem_rd_o         = mem_q.rd;
  assign bus.dmem_req_o       = w_memop;
  assign bus.dmem_we_o        = w_memop & mem_q.mem_write;

  assign bus.wb_reg_write_o  = wb_q.valid & wb_q.reg_write;
  assign bus.wb_mem_to_reg_o = wb_q.valid & wb_q.mem_to_reg;
  assign bus.wb_rd_o         = wb_q.rd;

  assign bus.mem_timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl : scenario bench for pipeline_ctrl with an expected-value queue (rev 1.0)
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int C_MAX_WAIT = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       rw;
    logic       src;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       br;
    logic [1:0] alu_op;
  } instr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [11:0] sb_q[$];

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.MAX_WAIT(C_MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t f_nop();
    instr_t t = '0;
    return t;
  endfunction

  function automatic instr_t f_rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t t = '0;
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.u1 = 1'b1; t.u2 = 1'b1; t.rw = 1'b1; t.alu_op = 2'b10;
    return t;
  endfunction

  function automatic instr_t f_load(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t t = '0;
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.u1 = 1'b1;
    t.rw = 1'b1; t.src = 1'b1; t.mr = 1'b1; t.m2r = 1'b1;
    return t;
  endfunction

  function automatic instr_t f_store(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t t = '0;
    t.valid = 1'b1; t.rs1 = rs1; t.rs2 = rs2; t.u1 = 1'b1; t.u2 = 1'b1;
    t.src = 1'b1; t.mw = 1'b1;
    return t;
  endfunction

  function automatic instr_t f_branch(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t t = '0;
    t.valid = 1'b1; t.rs1 = rs1; t.rs2 = rs2; t.u1 = 1'b1; t.u2 = 1'b1;
    t.br = 1'b1; t.alu_op = 2'b01;
    return t;
  endfunction

  // {pc_stall, if_id_stall, if_id_flush, ex_valid, fwd_a, fwd_b, mem_valid, dmem_req, dmem_we, mem_timeout}
  function automatic logic [11:0] mk(input logic ps, input logic fl, input logic exv,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic mv,
                                     input logic req, input logic we, input logic to);
    return {ps, ps, fl, exv, fa, fb, mv, req, we, to};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.pc_stall_o, bus.if_id_stall_o, bus.if_id_flush_o, bus.ex_valid_o,
            bus.fwd_a_o, bus.fwd_b_o, bus.mem_valid_o, bus.dmem_req_o, bus.dmem_we_o,
            bus.mem_timeout_o};
  endfunction

  function automatic logic [38:0] allout();
    return {bus.pc_stall_o, bus.if_id_stall_o, bus.if_id_flush_o, bus.ex_valid_o,
            bus.ex_reg_write_o, bus.ex_alu_src_o, bus.ex_mem_read_o, bus.ex_mem_write_o,
            bus.ex_mem_to_reg_o, bus.ex_branch_o, bus.ex_alu_op_o, bus.ex_rd_o,
            bus.fwd_a_o, bus.fwd_b_o, bus.mem_valid_o, bus.mem_reg_write_o,
            bus.mem_mem_to_reg_o, bus.mem_rd_o, bus.dmem_req_o, bus.dmem_we_o,
            bus.wb_reg_write_o, bus.wb_mem_to_reg_o, bus.wb_rd_o, bus.mem_timeout_o};
  endfunction

  task automatic drive(input instr_t t, input logic taken, input logic ack);
    bus.id_valid_i        = t.valid;
    bus.id_rd_i           = t.rd;
    bus.id_rs1_i          = t.rs1;
    bus.id_rs2_i          = t.rs2;
    bus.id_uses_rs1_i     = t.u1;
    bus.id_uses_rs2_i     = t.u2;
    bus.id_reg_write_i    = t.rw;
    bus.id_alu_src_i      = t.src;
    bus.id_mem_read_i     = t.mr;
    bus.id_mem_write_i    = t.mw;
    bus.id_mem_to_reg_i   = t.m2r;
    bus.id_branch_i       = t.br;
    bus.id_alu_op_i       = t.alu_op;
    bus.ex_branch_taken_i = taken;
    bus.dmem_ack_i        = ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(f_nop(), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [38:0] got;
    rst = 1'b1;
    drive(f_rtype(5'd3, 5'd1, 5'd2), 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    got = allout();
    checks++;
    if (got !== 39'd0) begin
      errors++;
      $display("FAIL reset_hold outputs got %h expected 0", got);
    end
    drive(f_nop(), 1'b0, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    got = allout();
    checks++;
    if (got !== 39'd0) begin
      errors++;
      $display("FAIL reset_release outputs got %h expected 0", got);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    instr_t prog[5];
    logic [11:0] ev[5];
    logic [11:0] e;
    do_reset();
    prog[0] = f_rtype(5'd1, 5'd2, 5'd3); ev[0] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[1] = f_rtype(5'd4, 5'd1, 5'd5); ev[1] = mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[2] = f_rtype(5'd6, 5'd1, 5'd4); ev[2] = mk(0, 0, 1, 2'b10, 2'b00, 1, 0, 0, 0);
    prog[3] = f_nop();                   ev[3] = mk(0, 0, 1, 2'b01, 2'b10, 1, 0, 0, 0);
    prog[4] = f_nop();                   ev[4] = mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(prog[i], 1'b0, 1'b1);
      sb_q.push_back(ev[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL b2b cycle %0d obs got %b expected %b", i, obs(), e);
      end
      if (i == 3) begin
        checks++;
        if ({bus.wb_reg_write_o, bus.wb_rd_o} !== {1'b1, 5'd1}) begin
          errors++;
          $display("FAIL b2b_wb {wb_reg_write,wb_rd} got %b expected %b",
                   {bus.wb_reg_write_o, bus.wb_rd_o}, {1'b1, 5'd1});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    instr_t prog[4];
    logic [11:0] ev[4];
    logic [3:0] ak;
    logic [11:0] e;
    do_reset();
    ak = 4'b0100;
    prog[0] = f_load(5'd5, 5'd2);        ev[0] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[1] = f_rtype(5'd6, 5'd5, 5'd0); ev[1] = mk(1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[2] = f_rtype(5'd6, 5'd5, 5'd0); ev[2] = mk(0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0);
    prog[3] = f_nop();                   ev[3] = mk(0, 0, 1, 2'b01, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(prog[i], 1'b0, ak[i]);
      sb_q.push_back(ev[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL loaduse cycle %0d obs got %b expected %b", i, obs(), e);
      end
      if (i == 1) begin
        checks++;
        if ({bus.ex_mem_read_o, bus.ex_rd_o} !== {1'b1, 5'd5}) begin
          errors++;
          $display("FAIL loaduse_ex {ex_mem_read,ex_rd} got %b expected %b",
                   {bus.ex_mem_read_o, bus.ex_rd_o}, {1'b1, 5'd5});
        end
      end
      if (i == 3) begin
        checks++;
        if ({bus.wb_mem_to_reg_o, bus.wb_rd_o} !== {1'b1, 5'd5}) begin
          errors++;
          $display("FAIL loaduse_wb {wb_mem_to_reg,wb_rd} got %b expected %b",
                   {bus.wb_mem_to_reg_o, bus.wb_rd_o}, {1'b1, 5'd5});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    instr_t prog[6];
    logic [11:0] ev[6];
    logic [5:0] tk;
    logic [11:0] e;
    do_reset();
    tk = 6'b000110;
    prog[0] = f_branch(5'd1, 5'd2);      ev[0] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[1] = f_rtype(5'd7, 5'd3, 5'd4); ev[1] = mk(0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[2] = f_nop();                   ev[2] = mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    prog[3] = f_rtype(5'd9, 5'd1, 5'd1); ev[3] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[4] = f_nop();                   ev[4] = mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[5] = f_nop();                   ev[5] = mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(prog[i], tk[i], 1'b0);
      sb_q.push_back(ev[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL branch cycle %0d obs got %b expected %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    instr_t prog[8];
    logic [11:0] ev[8];
    logic [7:0] tk;
    logic [7:0] ak;
    logic [11:0] e;
    do_reset();
    tk = 8'b0011_1100;
    ak = 8'b0010_0000;
    prog[0] = f_store(5'd2, 5'd3);         ev[0] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[1] = f_branch(5'd1, 5'd1);        ev[1] = mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[2] = f_rtype(5'd10, 5'd3, 5'd3);  ev[2] = mk(1, 0, 1, 2'b00, 2'b00, 1, 1, 1, 0);
    prog[3] = f_rtype(5'd10, 5'd3, 5'd3);  ev[3] = mk(1, 0, 1, 2'b00, 2'b00, 1, 1, 1, 0);
    prog[4] = f_rtype(5'd10, 5'd3, 5'd3);  ev[4] = mk(1, 0, 1, 2'b00, 2'b00, 1, 1, 1, 0);
    prog[5] = f_rtype(5'd10, 5'd3, 5'd3);  ev[5] = mk(0, 1, 1, 2'b00, 2'b00, 1, 1, 1, 1);
    prog[6] = f_nop();                     ev[6] = mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1);
    prog[7] = f_nop();                     ev[7] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(prog[i], tk[i], ak[i]);
      sb_q.push_back(ev[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL memwait cycle %0d obs got %b expected %b", i, obs(), e);
      end
      if (i == 4) begin
        checks++;
        if (bus.ex_branch_o !== 1'b1) begin
          errors++;
          $display("FAIL memwait_hold ex_branch got %b expected 1", bus.ex_branch_o);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout_reset();
    instr_t prog[7];
    logic [11:0] ev[7];
    logic [11:0] e;
    logic [38:0] got;
    do_reset();
    prog[0] = f_load(5'd4, 5'd1); ev[0] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[1] = f_nop();            ev[1] = mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[2] = f_nop();            ev[2] = mk(1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0);
    prog[3] = f_nop();            ev[3] = mk(1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0);
    prog[4] = f_nop();            ev[4] = mk(1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0);
    prog[5] = f_nop();            ev[5] = mk(1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1);
    prog[6] = f_nop();            ev[6] = mk(1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1);
    for (int i = 0; i < 7; i++) begin
      drive(prog[i], 1'b0, 1'b0);
      sb_q.push_back(ev[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL timeout cycle %0d obs got %b expected %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
    // Mid-cycle reset while still waiting: everything must drop without a clock edge.
    #1 rst = 1'b1;
    #1;
    got = allout();
    checks++;
    if (got !== 39'd0) begin
      errors++;
      $display("FAIL async_reset outputs got %h expected 0", got);
    end
    @(posedge clk); #1 rst = 1'b0;
    prog[0] = f_load(5'd4, 5'd1); ev[0] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[1] = f_nop();            ev[1] = mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    prog[2] = f_nop();            ev[2] = mk(0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0);
    prog[3] = f_nop();            ev[3] = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(prog[i], 1'b0, (i == 2));
      sb_q.push_back(ev[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL post_reset cycle %0d obs got %b expected %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(f_nop(), 1'b0, 1'b0);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
